// File: rtl/pokey_timer_bank.sv
// Bank of POKEY-style down-counting timers. Adjacent channel pairs can be
// linked into one double-width counter; underflow events leave through a delay line.
module pokey_timer_pair #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [1:0]          tick,
  input  logic [1:0]          wr_en,
  input  logic [W-1:0]        data_in,
  input  logic                link,
  input  logic                restart,
  output logic [1:0]          underflow,
  output logic [1:0][W-1:0]   count
);
  localparam logic [W-1:0]   ONE  = 1;
  localparam logic [2*W-1:0] ONE2 = 1;

  logic [1:0][W-1:0] r, c, c_tick;
  logic [1:0][D-1:0] pipe;
  logic [1:0]        ev;
  logic [2*W-1:0]    comb, comb_nxt;

  always_comb begin
    comb     = {c[1], c[0]};
    comb_nxt = (comb == '0) ? {r[1], r[0]} : comb - ONE2;
    ev       = '0;
    c_tick   = c;
    if (link) begin
      // Only the low tick drives a linked pair; its underflow lands on the high half
      ev[1] = tick[0] && (comb == '0) && !wr_en[0] && !wr_en[1] && !restart;
      if (tick[0]) c_tick = comb_nxt;
    end else begin
      for (int i = 0; i < 2; i++) begin
        ev[i] = tick[i] && (c[i] == '0) && !wr_en[i] && !restart;
        if (tick[i]) c_tick[i] = (c[i] == '0) ? r[i] : c[i] - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r    <= '0;
      c    <= '0;
      pipe <= '0;
    end else if (ce) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          r[i]    <= data_in;
          c[i]    <= data_in;
          pipe[i] <= '0;
        end else if (restart) begin
          c[i]    <= r[i];
          pipe[i] <= '0;
        end else begin
          c[i]    <= c_tick[i];
          pipe[i] <= (pipe[i] << 1) | D'(ev[i]);
        end
      end
    end
  end

  assign underflow[0] = pipe[0][D-1] & ~link;
  assign underflow[1] = pipe[1][D-1];
  assign count        = c;
endmodule

module pokey_timer_bank #(
  parameter int CHANNELS        = 4,
  parameter int WIDTH           = 8,
  parameter int UNDERFLOW_DELAY = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic [CHANNELS-1:0]         tick,
  input  logic [CHANNELS-1:0]         wr_en,
  input  logic [WIDTH-1:0]            data_in,
  input  logic [CHANNELS/2-1:0]       link,
  input  logic                        restart,
  output logic [CHANNELS-1:0]         underflow,
  output logic [CHANNELS*WIDTH-1:0]   count_out
);
  localparam int PAIRS = CHANNELS / 2;

  logic [PAIRS-1:0][1:0][WIDTH-1:0] pair_count;

  for (genvar k = 0; k < PAIRS; k++) begin : g_pair
    pokey_timer_pair #(.W(WIDTH), .D(UNDERFLOW_DELAY)) u_pair (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .tick      (tick[2*k +: 2]),
      .wr_en     (wr_en[2*k +: 2]),
      .data_in   (data_in),
      .link      (link[k]),
      .restart   (restart),
      .underflow (underflow[2*k +: 2]),
      .count     (pair_count[k])
    );
  end

  assign count_out = pair_count;
endmodule

// File: tb/tb_pokey_timer_bank.sv
// Directed plus random stimulus against a behavioural timer model; expected
// underflow vectors travel through a scoreboard queue of depth UNDERFLOW_DELAY.
module tb_pokey_timer_bank;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int D  = 3;

  logic              clk = 0;
  logic              reset_n;
  logic              ce;
  logic [CH-1:0]     tick, wr_en;
  logic [W-1:0]      data_in;
  logic [CH/2-1:0]   link;
  logic              restart;
  logic [CH-1:0]     underflow;
  logic [CH*W-1:0]   count_out;

  pokey_timer_bank #(.CHANNELS(CH), .WIDTH(W), .UNDERFLOW_DELAY(D)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .tick(tick), .wr_en(wr_en),
    .data_in(data_in), .link(link), .restart(restart),
    .underflow(underflow), .count_out(count_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0]  mr [CH];
  logic [W-1:0]  mc [CH];
  logic [CH-1:0] sb_q [$];
  int            uf1_seen;

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin mr[i] = '0; mc[i] = '0; end
    sb_q.delete();
    for (int i = 0; i < D; i++) sb_q.push_back('0);
  endtask

  task automatic model_update(input logic [CH-1:0] t, input logic [CH-1:0] wr,
                              input logic [W-1:0] d, input logic [CH/2-1:0] l,
                              input logic rs);
    logic [W-1:0]  nc [CH];
    logic [CH-1:0] ev;
    logic [2*W-1:0] cv;
    ev = '0;
    for (int i = 0; i < CH; i++) nc[i] = mc[i];
    for (int k = 0; k < CH/2; k++) begin
      if (l[k]) begin
        cv = {mc[2*k+1], mc[2*k]};
        if (t[2*k]) begin
          if (cv == 0) begin
            cv = {mr[2*k+1], mr[2*k]};
            ev[2*k+1] = !wr[2*k] && !wr[2*k+1] && !rs;
          end else cv = cv - 1;
        end
        nc[2*k] = cv[W-1:0];
        nc[2*k+1] = cv[2*W-1:W];
      end else begin
        for (int j = 2*k; j < 2*k+2; j++)
          if (t[j]) begin
            if (mc[j] == 0) begin nc[j] = mr[j]; ev[j] = !wr[j] && !rs; end
            else nc[j] = mc[j] - 1;
          end
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (wr[i]) begin mr[i] = d; mc[i] = d; end
      else if (rs) mc[i] = mr[i];
      else mc[i] = nc[i];
    end
    void'(sb_q.pop_front());
    sb_q.push_back(ev);
    for (int i = 0; i < D; i++) sb_q[i] = sb_q[i] & ~(wr | {CH{rs}});
  endtask

  task automatic check(input logic [CH/2-1:0] l);
    logic [CH*W-1:0] exp_c;
    logic [CH-1:0]   exp_u;
    for (int i = 0; i < CH; i++) exp_c[i*W +: W] = mc[i];
    exp_u = sb_q[0];
    for (int k = 0; k < CH/2; k++) if (l[k]) exp_u[2*k] = 1'b0;
    n_checks++;
    assert (count_out === exp_c) else begin
      n_fail++;
      $error("FAIL count_out got %h exp %h at %0t", count_out, exp_c, $time);
    end
    n_checks++;
    assert (underflow === exp_u) else begin
      n_fail++;
      $error("FAIL underflow got %b exp %b at %0t", underflow, exp_u, $time);
    end
    if (underflow[1]) uf1_seen++;
  endtask

  task automatic step(input logic c, input logic [CH-1:0] t, input logic [CH-1:0] wr,
                      input logic [W-1:0] d, input logic [CH/2-1:0] l, input logic rs);
    ce = c; tick = t; wr_en = wr; data_in = d; link = l; restart = rs;
    @(posedge clk);
    if (c) model_update(t, wr, d, l, rs);
    #1 check(l);
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    model_clear();
    n_checks++;
    assert (count_out === '0 && underflow === '0) else begin
      n_fail++;
      $error("FAIL reset_state got %h/%b exp 0/0", count_out, underflow);
    end
    @(posedge clk); #2;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 1; ce = 0; tick = 0; wr_en = 0; data_in = 0; link = 0; restart = 0;
    model_clear();
    #2 do_reset();
    // R=0 after reset: every tick underflows on every channel
    repeat (6) step(1, 4'b1111, 4'b0000, 8'h00, 2'b00, 0);
    // channel 0 reload 3, period 4
    step(1, 4'b0000, 4'b0001, 8'h03, 2'b00, 0);
    repeat (12) step(1, 4'b0001, 4'b0000, 8'h00, 2'b00, 0);
    // write to channel 2 while it would underflow
    step(1, 4'b0000, 4'b0100, 8'h00, 2'b00, 0);
    step(1, 4'b0100, 4'b0100, 8'h05, 2'b00, 0);
    repeat (5) step(1, 4'b0000, 4'b0000, 8'h00, 2'b00, 0);
    // linked pair 0: reload 0x0100, period 257
    step(1, 4'b0000, 4'b0010, 8'h01, 2'b01, 0);
    step(1, 4'b0000, 4'b0001, 8'h00, 2'b01, 0);
    uf1_seen = 0;
    repeat (520) step(1, 4'b0001, 4'b0000, 8'h00, 2'b01, 0);
    n_checks++;
    assert (uf1_seen == 2) else begin
      n_fail++;
      $error("FAIL linked_uf1_count got %0d exp 2", uf1_seen);
    end
    // pending event killed by restart
    step(1, 4'b0000, 4'b0010, 8'h00, 2'b00, 0);
    step(1, 4'b0010, 4'b0000, 8'h00, 2'b00, 0);
    step(1, 4'b0000, 4'b0000, 8'h00, 2'b00, 1);
    repeat (4) step(1, 4'b0000, 4'b0000, 8'h00, 2'b00, 0);
    // ce gating with tick held
    step(1, 4'b0000, 4'b0001, 8'h01, 2'b00, 0);
    repeat (10) begin
      step(1, 4'b0001, 4'b0000, 8'h00, 2'b00, 0);
      step(0, 4'b0001, 4'b0000, 8'h00, 2'b00, 0);
    end
    // reset mid-count with R[3]=0x10
    step(1, 4'b0000, 4'b1000, 8'h10, 2'b00, 0);
    repeat (20) step(1, 4'b1001, 4'b0000, 8'h00, 2'b00, 0);
    do_reset();
    repeat (6) step(1, 4'b0000, 4'b0000, 8'h00, 2'b00, 0);
    // random mix
    for (int n = 0; n < 300; n++)
      step(($urandom % 4) != 0, 4'($urandom), (($urandom % 6) == 0) ? 4'($urandom) : 4'b0000,
           8'($urandom % 6), (n < 150) ? 2'b00 : 2'b11, ($urandom % 20) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pokey_timer_bank.md
POKEY_TIMER_BANK -- requirements
Module: pokey_timer_bank

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, number of timer channels (even, >=2).
REQ-002 SHALL provide parameter WIDTH, default 8, bits per channel counter and reload register.
REQ-003 SHALL provide parameter UNDERFLOW_DELAY, default 3, ce-qualified stages between underflow event and output pulse (>=1).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 ce  input  1  global clock enable; no state changes when 0.
REQ-007 tick  input  CHANNELS  per-channel count enable (prescaled timebase).
REQ-008 wr_en  input  CHANNELS  per-channel reload-register write strobe.
REQ-009 data_in  input  WIDTH  write data shared by all channels.
REQ-010 link  input  CHANNELS/2  bit k joins channels 2k (low) and 2k+1 (high) into one 2*WIDTH counter.
REQ-011 restart  input  1  reload all counters from their reload registers.
REQ-012 underflow  output  CHANNELS  one-ce-cycle pulse per delayed underflow event.
REQ-013 count_out  output  CHANNELS*WIDTH  current counter values, channel i at bits [i*WIDTH +: WIDTH].

Function
REQ-014 Each channel i SHALL hold reload register R[i] and counter C[i], both WIDTH bits.
REQ-015 All updates SHALL occur only on cycles with ce=1.
REQ-016 wr_en[i]: R[i] and C[i] <= data_in; the channel's delay pipeline cleared; no event that cycle.
REQ-017 Unlinked channel, tick[i]=1, C[i]!=0: C[i] <= C[i]-1 (modulo 2^WIDTH).
REQ-018 Unlinked channel, tick[i]=1, C[i]==0: underflow event generated, C[i] <= R[i]; period = R[i]+1 ticks.
REQ-019 Linked pair k: combined counter {C[2k+1],C[2k]} SHALL decrement as one 2*WIDTH value on tick[2k]; tick[2k+1] ignored.
REQ-020 Linked pair k, tick[2k]=1, combined value 0: event on channel 2k+1 only; both halves reload from {R[2k+1],R[2k]}.
REQ-021 Linked pair: underflow[2k] SHALL stay 0; wr_en to either half affects only that half's R and C.
REQ-022 link changes SHALL take effect the next ce cycle without modifying counters or reload registers.
REQ-023 restart: every C[i] <= R[i] and all delay pipelines cleared; no events that cycle.
REQ-024 Priority per channel: wr_en[i] > restart > tick.
REQ-025 Delay pipeline: UNDERFLOW_DELAY-stage shift register per channel advancing only on ce=1; event at cycle n appears on underflow[i] at ce cycle n+UNDERFLOW_DELAY for exactly one ce cycle.
REQ-026 Back-to-back events (R=0, tick every cycle) SHALL produce underflow high every ce cycle after the delay; no events lost or merged.
REQ-027 count_out SHALL be registered counter state (no combinational path from tick).

Reset
REQ-028 reset_n=0 SHALL asynchronously clear all R, C and delay stages; underflow=0, count_out=0 while asserted.
REQ-029 After reset with tick active and R=0, each channel SHALL underflow on every tick (C==0 reload to 0).
REQ-030 Reset asserted mid-count SHALL discard pending pipeline events; none appear after release.

Verification
REQ-031 Defaults; wr_en[0] data 3; tick[0] every ce -> C[0] 3,2,1,0,3; underflow[0] pulses 3 ce cycles after each C[0]==0 tick, period 4.
REQ-032 link[0]=1, R[1]=0x01, R[0]=0x00 written, tick[0] continuous -> count_out pair 0x0100,0x00FF..0x0000, reload 0x0100; underflow[1] every 257 ticks; underflow[0] never.
REQ-033 wr_en[2] same cycle as tick[2] with C[2]==0 -> C[2]=data_in, no underflow[2] pulse ever appears.
REQ-034 Event pending in pipeline, restart asserted -> pulse suppressed; all C equal R next cycle.
REQ-035 ce toggling 1,0,1,0 with tick held 1 -> counter and pipeline advance only on ce=1 cycles; pulse width one ce cycle.
REQ-036 reset_n pulsed low mid-count with R[3]=0x10 -> R[3]=C[3]=0, underflow=0 immediately, no residual pulses.
